// File: rtl/boot_loader_pkg.sv
// Shared rv32i parameter set, loader FSM state encodings and BRAM byte stride.
package boot_loader_pkg;

   localparam int RV32I_XLEN       = 32;
   localparam int RV32I_ADDR_WIDTH = 10;

   // BRAM words are 32-bit, addressed by byte
   localparam int BYTE_STRIDE = 4;
   localparam int WORD_SHIFT  = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_D  = 3'd1,
      ST_LOAD_I  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Word stream in plus the data and instruction BRAM write ports.
interface boot_loader_if
   import boot_loader_pkg::*;
#(
   parameter int DATA_WIDTH = RV32I_XLEN,
   parameter int ADDR_WIDTH = RV32I_ADDR_WIDTH
);

   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;

   logic [ADDR_WIDTH-1:0] d_w_addr;
   logic [DATA_WIDTH-1:0] d_w_dat;
   logic                  d_w_enb;

   logic [ADDR_WIDTH-1:0] i_w_addr;
   logic [DATA_WIDTH-1:0] i_w_dat;
   logic                  i_w_enb;

   // slave: the loader (consumes the stream, owns the write ports)
   modport slave (
      input  s_valid, s_data,
      output s_ready,
      output d_w_addr, d_w_dat, d_w_enb,
      output i_w_addr, i_w_dat, i_w_enb
   );

   // master: the stream source and the memories behind the write ports
   modport master (
      output s_valid, s_data,
      input  s_ready,
      input  d_w_addr, d_w_dat, d_w_enb,
      input  i_w_addr, i_w_dat, i_w_enb
   );

endinterface

// File: rtl/boot_loader_wr_port_reg.sv
// Registered BRAM write-port stage; address/data hold their last written value.
module boot_loader_wr_port_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enb_d_i,
   input  logic [ADDR_WIDTH-1:0] addr_d_i,
   input  logic [DATA_WIDTH-1:0] dat_d_i,
   output logic                  enb_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] dat_o
);

   logic                  enb_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] dat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enb_q  <= 1'b0;
         addr_q <= '0;
         dat_q  <= '0;
      end else begin
         enb_q <= enb_d_i;
         if (enb_d_i) begin
            addr_q <= addr_d_i;
            dat_q  <= dat_d_i;
         end
      end
   end

   assign enb_o  = enb_q;
   assign addr_o = addr_q;
   assign dat_o  = dat_q;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams data words then instruction words into two BRAMs
// while holding the CPU stalled, then releases it.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int DATA_WIDTH = RV32I_XLEN,
   parameter int ADDR_WIDTH = RV32I_ADDR_WIDTH,
   parameter int CNT_WIDTH  = ADDR_WIDTH - 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [CNT_WIDTH-1:0] d_count_i,
   input  logic [CNT_WIDTH-1:0] i_count_i,
   output logic                 cpu_stall_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   boot_loader_if.slave         bus
);

   localparam int                   IDX_WIDTH   = ADDR_WIDTH - WORD_SHIFT;
   localparam int                   DEPTH_WORDS = 1 << IDX_WIDTH;
   localparam logic [CNT_WIDTH-1:0] DEPTH_CNT   = CNT_WIDTH'(DEPTH_WORDS);

   state_e                 state_q, state_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic [CNT_WIDTH-1:0]   d_cnt_q, d_cnt_d;
   logic [CNT_WIDTH-1:0]   i_cnt_q, i_cnt_d;
   logic                   err_q, err_d;

   logic                   d_over, i_over;
   logic [CNT_WIDTH-1:0]   d_sat, i_sat;
   logic                   in_load;
   logic                   beat;
   logic [CNT_WIDTH-1:0]   cur_cnt;
   logic                   last_beat;

   // index 0 = data port, index 1 = instruction port
   logic [1:0]             wr_enb_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_d;
   logic [DATA_WIDTH-1:0]  wr_dat_d;
   logic [1:0]             wr_enb_q;
   logic [ADDR_WIDTH-1:0]  wr_addr_q [2];
   logic [DATA_WIDTH-1:0]  wr_dat_q  [2];

   assign d_over = (d_count_i > DEPTH_CNT);
   assign i_over = (i_count_i > DEPTH_CNT);
   assign d_sat  = d_over ? DEPTH_CNT : d_count_i;
   assign i_sat  = i_over ? DEPTH_CNT : i_count_i;

   assign in_load   = (state_q == ST_LOAD_D) || (state_q == ST_LOAD_I);
   assign beat      = in_load && bus.s_valid;
   assign cur_cnt   = (state_q == ST_LOAD_I) ? i_cnt_q : d_cnt_q;
   assign last_beat = ((CNT_WIDTH'(idx_q) + CNT_WIDTH'(1)) == cur_cnt);

   assign wr_addr_d = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(BYTE_STRIDE);
   assign wr_dat_d  = bus.s_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         d_cnt_q <= '0;
         i_cnt_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         d_cnt_q <= d_cnt_d;
         i_cnt_q <= i_cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      d_cnt_d  = d_cnt_q;
      i_cnt_d  = i_cnt_q;
      err_d    = err_q;
      wr_enb_d = 2'b00;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               d_cnt_d = d_sat;
               i_cnt_d = i_sat;
               idx_d   = '0;
               err_d   = d_over || i_over;
               if (d_sat != '0)      state_d = ST_LOAD_D;
               else if (i_sat != '0) state_d = ST_LOAD_I;
               else                  state_d = ST_RELEASE;
            end
         end

         ST_LOAD_D, ST_LOAD_I: begin
            // abort outranks a concurrent beat: that word is never written
            if (abort_i) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (beat) begin
               wr_enb_d[(state_q == ST_LOAD_I) ? 1 : 0] = 1'b1;
               if (last_beat) begin
                  idx_d = '0;
                  if (state_q == ST_LOAD_D && i_cnt_q != '0) state_d = ST_LOAD_I;
                  else                                       state_d = ST_RELEASE;
               end else begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
            end
         end

         ST_RELEASE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_wr_port
      boot_loader_wr_port_reg #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_wr_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .enb_d_i  (wr_enb_d[gi]),
         .addr_d_i (wr_addr_d),
         .dat_d_i  (wr_dat_d),
         .enb_o    (wr_enb_q[gi]),
         .addr_o   (wr_addr_q[gi]),
         .dat_o    (wr_dat_q[gi])
      );
   end

   assign bus.s_ready  = in_load;
   assign bus.d_w_enb  = wr_enb_q[0];
   assign bus.d_w_addr = wr_addr_q[0];
   assign bus.d_w_dat  = wr_dat_q[0];
   assign bus.i_w_enb  = wr_enb_q[1];
   assign bus.i_w_addr = wr_addr_q[1];
   assign bus.i_w_dat  = wr_dat_q[1];

   // the CPU owns the data BRAM only once the load has completed
   assign cpu_stall_o = (state_q != ST_DONE);
   assign done_o      = (state_q == ST_DONE);
   assign busy_o      = in_load || (state_q == ST_RELEASE);
   assign err_o       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomised bench: expected BRAM write sequence and status built from the load rules.
module tb_boot_loader;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int CW    = 9;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [CW-1:0] d_count_i = '0;
   logic [CW-1:0] i_count_i = '0;
   logic          cpu_stall_o, busy_o, done_o, err_o;

   always #5 clk = ~clk;

   boot_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .d_count_i   (d_count_i),
      .i_count_i   (i_count_i),
      .cpu_stall_o (cpu_stall_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .bus         (bus)
   );

   typedef struct {
      bit            port;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // every write seen on either port must be the next one the model expects
   wr_t mon_e;
   bit  mon_port;
   always @(negedge clk) begin
      if (rst_n && (bus.d_w_enb || bus.i_w_enb)) begin
         if (bus.d_w_enb && bus.i_w_enb) begin
            check("dual_wr", {bus.d_w_enb, bus.i_w_enb}, 2'b01);
         end else if (exp_q.size() == 0) begin
            check("unexpected_wr", bus.d_w_enb | bus.i_w_enb, 1'b0);
         end else begin
            mon_e    = exp_q.pop_front();
            mon_port = bus.i_w_enb;
            check("wr_port", mon_port, mon_e.port);
            check("wr_addr", mon_port ? bus.i_w_addr : bus.d_w_addr, mon_e.addr);
            check("wr_dat", mon_port ? bus.i_w_dat : bus.d_w_dat, mon_e.dat);
            $display("wr %s addr=0x%03h dat=0x%08h", mon_port ? "I" : "D",
                     mon_port ? bus.i_w_addr : bus.d_w_addr, mon_port ? bus.i_w_dat : bus.d_w_dat);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_s_ready"}, bus.s_ready, 1'b0);
      check({tag, "_cpu_stall"}, cpu_stall_o, 1'b1);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_done"}, done_o, 1'b0);
      check({tag, "_err"}, err_o, 1'b0);
      check({tag, "_wr_enb"}, {bus.d_w_enb, bus.i_w_enb}, 2'b00);
      check({tag, "_addr"}, {bus.d_w_addr, bus.i_w_addr}, '0);
      check({tag, "_dat"}, {bus.d_w_dat, bus.i_w_dat}, '0);
   endtask

   // vmode: 0 valid always, 1 toggling, 2 random; abort_at/rst_at: beats before abort/reset (-1 none)
   task automatic do_load(input int dc, input int ic, input int vmode, input int abort_at,
                          input int rst_at, input bit poke_start, input bit start_abort);
      int            ds, is_, total, ptr, cyc, stall_cyc;
      bit            aborted, finished, v, exp_err;
      logic [DW-1:0] words[$];

      ds      = (dc > DEPTH) ? DEPTH : dc;
      is_     = (ic > DEPTH) ? DEPTH : ic;
      total   = ds + is_;
      exp_err = (dc > DEPTH) || (ic > DEPTH);
      for (int k = 0; k < total; k++) begin
         words.push_back($urandom);
         if (abort_at < 0 || k < abort_at)
            exp_q.push_back('{port: (k >= ds), addr: AW'((k < ds ? k : k - ds) * 4), dat: words[k]});
      end

      @(negedge clk);
      start_i     = 1'b1;
      abort_i     = start_abort;
      d_count_i   = CW'(dc);
      i_count_i   = CW'(ic);
      bus.s_valid = 1'b0;
      ptr = 0; cyc = 0; stall_cyc = -1; aborted = 0; finished = 0;

      while (cyc < 4000 && !finished) begin
         @(negedge clk);
         cyc++;
         start_i = 1'b0;
         abort_i = 1'b0;
         if (cyc == 1) check("stall_after_start", cpu_stall_o, 1'b1);
         if (aborted) begin
            check("abort_busy", busy_o, 1'b0);
            check("abort_done", done_o, 1'b0);
            check("abort_stall", cpu_stall_o, 1'b1);
            check("abort_err", err_o, 1'b1);
            check("abort_s_ready", bus.s_ready, 1'b0);
            finished = 1;
         end else if (rst_at >= 0 && ptr >= rst_at) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1 check_reset_vals("midload_rst");
            exp_q.delete();
            repeat (3) @(negedge clk);
            rst_n       = 1'b1;
            bus.s_valid = 1'b1;
            repeat (6) @(negedge clk);
            bus.s_valid = 1'b0;
            check("post_rst_busy", busy_o, 1'b0);
            check("post_rst_stall", cpu_stall_o, 1'b1);
            finished = 1;
         end else begin
            if (!cpu_stall_o && stall_cyc < 0) stall_cyc = cyc;
            if (done_o) begin
               finished = 1;
            end else if (abort_at >= 0 && ptr == abort_at) begin
               abort_i     = 1'b1;
               bus.s_valid = 1'b0;
               aborted     = 1;
            end else begin
               if (poke_start && cyc == 3 && busy_o) begin
                  start_i   = 1'b1;
                  d_count_i = CW'($urandom_range(0, 40));
                  i_count_i = CW'($urandom_range(0, 40));
               end
               case (vmode)
                  0:       v = 1'b1;
                  1:       v = cyc[0];
                  default: v = ($urandom_range(0, 2) != 0);
               endcase
               bus.s_valid = v && (ptr < total);
               bus.s_data  = (ptr < total) ? words[ptr] : $urandom;
               if (bus.s_valid && bus.s_ready) ptr++;
            end
         end
      end
      bus.s_valid = 1'b0;

      if (!finished) begin
         check("load_timeout", done_o, 1'b1);
      end else if (!aborted && rst_at < 0) begin
         check("done_busy", busy_o, 1'b0);
         check("done_stall", cpu_stall_o, 1'b0);
         check("done_err", err_o, exp_err);
         check("done_s_ready", bus.s_ready, 1'b0);
         check("pending_wr", exp_q.size(), 0);
         if (vmode == 0) check("stall_latency", stall_cyc, total + 2);
      end else if (aborted) begin
         check("abort_pending_wr", exp_q.size(), 0);
      end
      $display("load d=%0d i=%0d mode=%0d abort_at=%0d rst_at=%0d cycles=%0d", dc, ic, vmode,
               abort_at, rst_at, cyc);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      rst_n = 1'b1;
      @(negedge clk);

      do_load(10, 3, 0, -1, -1, 0, 0);
      do_load(0, 3, 0, -1, -1, 0, 0);
      do_load(4, 0, 1, -1, -1, 0, 0);
      do_load(10, 5, 0, 2, -1, 0, 0);
      do_load(300, 2, 0, -1, -1, 0, 0);
      do_load(0, 0, 0, -1, -1, 0, 1);
      for (int r = 0; r < 6; r++)
         do_load($urandom_range(0, 20), $urandom_range(1, 20), 2, -1, -1, 1, r[0]);
      do_load(2, 6, 0, -1, 4, 0, 0);

      // abort while idle is ignored
      @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("idle_abort_err", err_o, 1'b0);
      check("idle_abort_stall", cpu_stall_o, 1'b1);
      check("idle_abort_busy", busy_o, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
